adder_tree_pipe: RTL and testbench

- Parametrised, fully pipelined N-input adder tree with an optional running accumulator on its output.
- Streams one input vector per cycle, with one register stage per tree level and a valid bit carried alongside the data.
- Serves as the registered successor to the combinational 16x4-bit tree benchmark and as an eFPGA timing/regression benchmark with real sequential depth.

---
 rtl/adder_tree_pipe.sv | 127 ++++++++++++
 tb/tb_adder_tree_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_pipe.sv
// Fully pipelined N-input adder tree, one register stage per level, with a
// running accumulator and sticky overflow flag on the tree output.
module adder_tree_pipe #(
  parameter int N_IN   = 16,
  parameter int W_IN   = 4,
  parameter int SIGNED = 0,
  parameter int W_ACC  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_IN*W_IN-1:0]              data_i,
  input  logic                              valid_i,
  input  logic                              first_i,
  output logic [W_IN+$clog2(N_IN)-1:0]      sum_o,
  output logic                              valid_o,
  output logic [W_ACC-1:0]                  acc_o,
  output logic                              acc_valid_o,
  output logic                              ovf_o
);

  localparam int LV    = $clog2(N_IN);
  localparam int W_SUM = W_IN + LV;
  localparam bit SGN   = (SIGNED != 0);

  // Level gi holds N_IN>>gi partial sums, each one bit wider than its sources.
  for (genvar gi = 1; gi <= LV; gi++) begin : g_lvl
    localparam int NE = N_IN >> gi;
    localparam int WA = W_IN + gi - 1;
    localparam int WO = WA + 1;

    logic [2*NE*WA-1:0] src;
    logic               src_valid;
    logic               src_first;
    logic [NE*WO-1:0]   sum_next;
    logic [NE*WO-1:0]   sum_reg;
    logic               valid_reg;
    logic               first_reg;

    if (gi == 1) begin : g_src
      assign src       = data_i;
      assign src_valid = valid_i;
      assign src_first = first_i;
    end else begin : g_src
      assign src       = g_lvl[gi-1].sum_reg;
      assign src_valid = g_lvl[gi-1].valid_reg;
      assign src_first = g_lvl[gi-1].first_reg;
    end

    for (genvar gj = 0; gj < NE; gj++) begin : g_add
      logic [WA-1:0] a;
      logic [WA-1:0] b;
      assign a = src[(2*gj)*WA +: WA];
      assign b = src[(2*gj+1)*WA +: WA];
      assign sum_next[gj*WO +: WO] = {SGN & a[WA-1], a} + {SGN & b[WA-1], b};
    end

    // Data only moves with a valid token so the output holds across bubbles.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sum_reg   <= '0;
        valid_reg <= 1'b0;
        first_reg <= 1'b0;
      end else begin
        valid_reg <= src_valid;
        first_reg <= src_valid & src_first;
        if (src_valid) begin
          sum_reg <= sum_next;
        end
      end
    end
  end

  logic               last_first;
  logic [W_ACC-1:0]   sum_ext;
  logic [W_ACC-1:0]   acc_reg;
  logic [W_ACC-1:0]   acc_next;
  logic [W_ACC:0]     add_full;
  logic               acc_valid_reg;
  logic               ovf_reg;
  logic               ovf_det;

  assign sum_o      = g_lvl[LV].sum_reg;
  assign valid_o    = g_lvl[LV].valid_reg;
  assign last_first = g_lvl[LV].first_reg;

  if (SGN) begin : g_ext
    assign sum_ext = W_ACC'($signed(sum_o));
  end else begin : g_ext
    assign sum_ext = W_ACC'(sum_o);
  end

  always_comb begin
    add_full = {1'b0, acc_reg} + {1'b0, sum_ext};
    acc_next = add_full[W_ACC-1:0];
    if (SGN) begin
      ovf_det = (acc_reg[W_ACC-1] == sum_ext[W_ACC-1]) &&
                (acc_next[W_ACC-1] != acc_reg[W_ACC-1]);
    end else begin
      ovf_det = add_full[W_ACC];
    end
  end

  // A first-flagged result reloads the accumulator and clears the sticky flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_reg       <= '0;
      acc_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      acc_valid_reg <= valid_o;
      if (valid_o) begin
        if (last_first) begin
          acc_reg <= sum_ext;
          ovf_reg <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          ovf_reg <= ovf_reg | ovf_det;
        end
      end
    end
  end

  assign acc_o       = acc_reg;
  assign acc_valid_o = acc_valid_reg;
  assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench: three instances (unsigned/16, unsigned/10, signed/16)
// share one stimulus stream and are compared against a delay-line model.
module tb_adder_tree_pipe;

  localparam int LV   = 4;
  localparam int MAXH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic        valid = 1'b0;
  logic        first = 1'b0;

  logic [7:0]  sum_u, sum_w, sum_s;
  logic        valid_u, valid_w, valid_s;
  logic [15:0] acc_u, acc_s;
  logic [9:0]  acc_w;
  logic        accv_u, accv_w, accv_s;
  logic        ovf_u, ovf_w, ovf_s;

  adder_tree_pipe #(.N_IN(16), .W_IN(4), .SIGNED(0), .W_ACC(16)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .first_i(first),
    .sum_o(sum_u), .valid_o(valid_u), .acc_o(acc_u), .acc_valid_o(accv_u), .ovf_o(ovf_u));

  adder_tree_pipe #(.N_IN(16), .W_IN(4), .SIGNED(0), .W_ACC(10)) dut_w (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .first_i(first),
    .sum_o(sum_w), .valid_o(valid_w), .acc_o(acc_w), .acc_valid_o(accv_w), .ovf_o(ovf_w));

  adder_tree_pipe #(.N_IN(16), .W_IN(4), .SIGNED(1), .W_ACC(16)) dut_s (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .first_i(first),
    .sum_o(sum_s), .valid_o(valid_s), .acc_o(acc_s), .acc_valid_o(accv_s), .ovf_o(ovf_s));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: every accepted vector is recorded by edge number; outputs are
  // that record read LV-1 edges later, accumulation one edge after that.
  int          n_edge;
  bit          rv [MAXH];
  bit          rf [MAXH];
  int          ru [MAXH];
  int          rs [MAXH];
  bit          e_valid, e_accv;
  int          e_sum_u, e_sum_s;
  int          acc16, acc10;
  logic [15:0] accs;
  bit          ovf16, ovf10, ovfs;

  localparam logic [63:0] ALL15 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] RAMP  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] ALT   = 64'h7878_7878_7878_7878;

  function automatic int usum(logic [63:0] d);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(d[k*4 +: 4]);
    return s;
  endfunction

  function automatic int ssum(logic [63:0] d);
    int s = 0;
    logic signed [3:0] x;
    for (int k = 0; k < 16; k++) begin
      x = d[k*4 +: 4];
      s += int'(x);
    end
    return s;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    e_valid = 0; e_accv = 0; e_sum_u = 0; e_sum_s = 0;
    acc16 = 0; acc10 = 0; accs = '0;
    ovf16 = 0; ovf10 = 0; ovfs = 0;
  endtask

  task automatic model_edge(input logic v, input logic f, input logic [63:0] d);
    int k, t;
    n_edge++;
    rv[n_edge] = v; rf[n_edge] = f; ru[n_edge] = usum(d); rs[n_edge] = ssum(d);
    k = n_edge - LV;
    e_accv = 0;
    if (k >= 1 && rv[k]) begin
      e_accv = 1;
      if (rf[k]) begin
        acc16 = ru[k] % 65536; ovf16 = 0;
        acc10 = ru[k] % 1024;  ovf10 = 0;
        t = rs[k]; accs = t[15:0]; ovfs = 0;
      end else begin
        t = acc16 + ru[k]; if (t >= 65536) ovf16 = 1; acc16 = t % 65536;
        t = acc10 + ru[k]; if (t >= 1024) ovf10 = 1; acc10 = t % 1024;
        t = int'($signed(accs)) + rs[k];
        if (t > 32767 || t < -32768) ovfs = 1;
        accs = t[15:0];
      end
    end
    k = n_edge - LV + 1;
    e_valid = (k >= 1) && rv[k];
    if (e_valid) begin
      e_sum_u = ru[k];
      e_sum_s = rs[k];
    end
  endtask

  task automatic check_all();
    chk("valid_o", valid_u, e_valid);
    chk("sum_o", sum_u, e_sum_u[7:0]);
    chk("acc_valid_o", accv_u, e_accv);
    chk("acc_o", acc_u, acc16);
    chk("ovf_o", ovf_u, ovf16);
    chk("w_valid_o", valid_w, e_valid);
    chk("w_sum_o", sum_w, e_sum_u[7:0]);
    chk("w_acc_valid_o", accv_w, e_accv);
    chk("w_acc_o", acc_w, acc10);
    chk("w_ovf_o", ovf_w, ovf10);
    chk("s_valid_o", valid_s, e_valid);
    chk("s_sum_o", sum_s, e_sum_s[7:0]);
    chk("s_acc_valid_o", accv_s, e_accv);
    chk("s_acc_o", acc_s, accs);
    chk("s_ovf_o", ovf_s, ovfs);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, valid_u | valid_w | valid_s, 0);
    chk({tag, "_accv"}, accv_u | accv_w | accv_s, 0);
    chk({tag, "_ovf"}, ovf_u | ovf_w | ovf_s, 0);
    chk({tag, "_sum_u"}, sum_u, 0);
    chk({tag, "_sum_s"}, sum_s, 0);
    chk({tag, "_acc_u"}, acc_u, 0);
    chk({tag, "_acc_w"}, acc_w, 0);
    chk({tag, "_acc_s"}, acc_s, 0);
  endtask

  task automatic cycle(input logic v, input logic f, input logic [63:0] d);
    valid = v; first = f; data = d;
    @(posedge clk);
    model_edge(v, f, d);
    @(negedge clk);
    check_all();
    $display("cyc %0d v=%0b f=%0b d=%h | vo=%0b sum=%0d acc=%0d av=%0b ovf=%0b | acc_w=%0d ovf_w=%0b | s_sum=%h s_acc=%h",
             n_edge, v, f, d, valid_u, sum_u, acc_u, accv_u, ovf_u, acc_w, ovf_w, sum_s, acc_s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'd0);
  endtask

  // Single all-15 vector: one valid_o pulse four stages later, then one update.
  task automatic seq_single(input string tag, input int acc_before);
    cycle(1'b1, 1'b0, ALL15);
    chk({tag, "_acc_before"}, acc_u, acc_before);
    idle(2);
    chk({tag, "_early_valid"}, valid_u, 0);
    idle(1);
    chk({tag, "_valid"}, valid_u, 1);
    chk({tag, "_sum"}, sum_u, 240);
    idle(1);
    chk({tag, "_valid_drop"}, valid_u, 0);
    chk({tag, "_accv"}, accv_u, 1);
    chk({tag, "_acc"}, acc_u, acc_before + 240);
    idle(1);
    chk({tag, "_accv_drop"}, accv_u, 0);
    idle(3);
  endtask

  typedef struct {
    logic [63:0] d;
    int          exp_u;
    int          exp_s;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int          pulses;
    int          exp_v[4];
    int          exp_sm[4];
    int          exp_aw[6];
    int          exp_ow[6];
    int          tmp;
    logic [63:0] d;
    logic        v, f;

    tbl[0] = '{ALL15, 240, -16};
    tbl[1] = '{RAMP, 120, -8};
    tbl[2] = '{ONES, 16, 16};
    tbl[3] = '{64'd0, 0, 0};
    tbl[4] = '{ALT, 120, -8};
    tbl[5] = '{64'h8888_8888_8888_8888, 128, -128};
    tbl[6] = '{64'h7777_7777_7777_7777, 112, 112};

    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    seq_single("s1", 0);

    // Ramp, all-ones, bubble, all-zero
    cycle(1'b1, 1'b0, RAMP);
    cycle(1'b1, 1'b0, ONES);
    cycle(1'b0, 1'b0, 64'd0);
    cycle(1'b1, 1'b0, 64'd0);
    exp_v = '{1, 1, 0, 1};
    exp_sm = '{120, 16, 16, 0};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(1);
      chk("s2_valid", valid_u, exp_v[i]);
      chk("s2_sum", sum_u, exp_sm[i]);
    end
    idle(5);

    // first-flagged all-ones then three more
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) cycle(1'b1, 1'b1, ONES);
      else if (i < 4) cycle(1'b1, 1'b0, ONES);
      else idle(1);
      pulses += int'(accv_u);
      if (i >= 4 && i <= 7) begin
        chk("s3_accv", accv_u, 1);
        chk("s3_acc", acc_u, 16 * (i - 3));
        chk("s3_ovf", ovf_u, 0);
      end
    end
    chk("s3_pulses", pulses, 4);

    // 10-bit accumulator wrap, then reload with zero
    exp_aw = '{240, 480, 720, 960, 176, 0};
    exp_ow = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 12; i++) begin
      if (i == 0) cycle(1'b1, 1'b1, ALL15);
      else if (i < 5) cycle(1'b1, 1'b0, ALL15);
      else if (i == 5) cycle(1'b1, 1'b1, 64'd0);
      else idle(1);
      if (i >= 4 && i <= 9) begin
        chk("s4_accv", accv_w, 1);
        chk("s4_acc_w", acc_w, exp_aw[i-4]);
        chk("s4_ovf_w", ovf_w, exp_ow[i-4]);
      end
    end
    idle(2);

    // Signed: -8 (first) then -16 accumulates to -24
    for (int i = 0; i < 8; i++) begin
      if (i == 0) cycle(1'b1, 1'b1, ALT);
      else if (i == 1) cycle(1'b1, 1'b0, ALL15);
      else idle(1);
      if (i == 3) chk("s5_sum_m8", sum_s, 8'hF8);
      if (i == 4) begin
        chk("s5_sum_m16", sum_s, 8'hF0);
        chk("s5_acc_m8", acc_s, 16'hFFF8);
      end
      if (i == 5) begin
        chk("s5_acc_m24", acc_s, 16'hFFE8);
        chk("s5_ovf", ovf_s, 0);
      end
    end
    idle(2);

    // Table of single vectors through both signednesses
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, tbl[i].d);
      idle(3);
      chk("tbl_valid", valid_u, 1);
      chk("tbl_sum_u", sum_u, tbl[i].exp_u);
      tmp = tbl[i].exp_s;
      chk("tbl_sum_s", sum_s, tmp[7:0]);
    end
    idle(3);

    // Async reset mid-cycle with three vectors in flight
    cycle(1'b1, 1'b0, ALL15);
    cycle(1'b1, 1'b0, ONES);
    cycle(1'b1, 1'b0, RAMP);
    valid = 1'b0; first = 1'b0; data = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("post_rst_valid", valid_u, 0);
      chk("post_rst_accv", accv_u, 0);
    end
    seq_single("s6", 0);

    // Randomised stream against the model
    for (int i = 0; i < 300; i++) begin
      v = ($urandom % 4) != 0;
      f = ($urandom % 6) == 0;
      case ($urandom % 5)
        0: d = ALL15;
        1: d = 64'h8888_8888_8888_8888;
        default: d = {$urandom, $urandom};
      endcase
      cycle(v, f, d);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
